// File: rtl/cpu_ctrl.sv
// Multi-cycle control sequencer for the 16-bit CPU: owns PC/IR/flags, walks
// FETCH -> EXEC [-> MEM], steers function-unit operands and sequences load/store.
module cpu_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [2:0]  rf_aa_out,
  output logic [2:0]  rf_ba_out,
  input  logic [15:0] rf_a_in,
  input  logic [15:0] rf_b_in,
  output logic        rf_we_out,
  output logic [2:0]  rf_da_out,
  output logic [15:0] rf_wd_out,
  output logic [3:0]  fu_fs_out,
  output logic [15:0] fu_a_out,
  output logic [15:0] fu_b_out,
  input  logic [15:0] fu_f_in,
  input  logic        fu_z_in,
  input  logic        fu_n_in,
  output logic        halted,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [2:0] CLS_ALU_R = 3'd0;
  localparam logic [2:0] CLS_ALU_I = 3'd1;
  localparam logic [2:0] CLS_LOAD  = 3'd2;
  localparam logic [2:0] CLS_STORE = 3'd3;
  localparam logic [2:0] CLS_BRZ   = 3'd4;
  localparam logic [2:0] CLS_BRN   = 3'd5;
  localparam logic [2:0] CLS_JMP   = 3'd6;
  localparam logic [2:0] CLS_HALT  = 3'd7;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        z_q, z_d;
  logic        n_q, n_d;

  logic [2:0]  cls, da, aa, ba;
  logic [3:0]  fs;
  logic [15:0] imm_ext, off_ext;
  logic        ir_live;

  assign cls     = ir_q[15:13];
  assign fs      = ir_q[12:9];
  assign da      = ir_q[8:6];
  assign aa      = ir_q[5:3];
  assign ba      = ir_q[2:0];
  assign imm_ext = {13'd0, ir_q[2:0]};
  assign off_ext = {{10{ir_q[8]}}, ir_q[8:6], ir_q[2:0]};

  // IR-derived outputs are only meaningful once an instruction is latched;
  // gating them keeps every output at 0 while in reset/IDLE/FETCH/HALT.
  assign ir_live = (state_q == S_EXEC) || (state_q == S_MEM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'd0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  // Handshake: a request is raised in FETCH/MEM and held, with address and
  // write data stable, until ack is sampled high on a rising edge; the FSM
  // leaves the state on that edge so the request drops the following cycle.
  // Acks seen in any other state are ignored.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    z_d       = z_q;
    n_d       = n_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we_out = 1'b0;
    rf_da_out = 3'd0;
    rf_wd_out = 16'd0;
    halted    = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (cls)
          CLS_ALU_R, CLS_ALU_I: begin
            rf_we_out = 1'b1;
            rf_da_out = da;
            rf_wd_out = fu_f_in;
            z_d       = fu_z_in;
            n_d       = fu_n_in;
          end
          CLS_LOAD, CLS_STORE: begin
            state_d = S_MEM;
          end
          // pc_q is already incremented, so a zero offset falls through.
          CLS_BRZ: begin
            if (z_q) pc_d = pc_q + off_ext;
          end
          CLS_BRN: begin
            if (n_q) pc_d = pc_q + off_ext;
          end
          CLS_JMP: begin
            pc_d = rf_a_in;
          end
          CLS_HALT: begin
            state_d = S_HALT;
          end
          default: begin
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_STORE);
        if (dmem_ack) begin
          state_d = S_FETCH;
          if (cls == CLS_LOAD) begin
            rf_we_out = 1'b1;
            rf_da_out = da;
            rf_wd_out = dmem_rdata;
          end
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_addr  = pc_q;
  assign rf_aa_out  = ir_live ? aa : 3'd0;
  assign rf_ba_out  = ir_live ? ba : 3'd0;
  assign fu_fs_out  = ir_live ? fs : 4'd0;
  assign fu_a_out   = ir_live ? rf_a_in : 16'd0;
  assign fu_b_out   = !ir_live ? 16'd0 : ((cls == CLS_ALU_I) ? imm_ext : rf_b_in);
  assign dmem_addr  = ir_live ? rf_a_in : 16'd0;
  assign dmem_wdata = ir_live ? rf_b_in : 16'd0;
  assign dbg_state  = state_q;

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control sequencer for the 16-bit CPU datapath. It fetches instructions over a request/acknowledge instruction-memory port and decodes them. It drives the function unit's function select, operands and register-file addresses, and captures the FU zero/negative flags for conditional branches. It also sequences load/store transfers on the data-memory port. It sits directly upstream of the function unit and owns the PC, IR and flag registers.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  16  fetch address (= PC)
- imem_ack  in  1  fetch data valid
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  16  data address (= rf_a_in)
- dmem_wdata  out  16  store data (= rf_b_in)
- dmem_ack  in  1  access complete; load data valid
- dmem_rdata  in  16  load data
- rf_aa_out, rf_ba_out  out  3 each  register-file read addresses
- rf_a_in, rf_b_in  in  16 each  register-file read data (combinational)
- rf_we_out  out  1  register write enable
- rf_da_out  out  3  write address
- rf_wd_out  out  16  write data
- fu_fs_out  out  4  FU function select (fs_t encoding)
- fu_a_out, fu_b_out  out  16 each  FU operands
- fu_f_in  in  16  FU result
- fu_z_in, fu_n_in  in  1 each  FU flags
- halted  out  1  core stopped

## Operation
- Instruction fields: cls = ir[15:13], fs = ir[12:9], da = ir[8:6], aa = ir[5:3], ba/imm3 = ir[2:0].
- Branch offset off6 = {ir[8:6], ir[2:0]}, sign-extended to 16 bits.
- Classes:
  - 000 ALU-reg: rf[da] <= FU(fs, rf[aa], rf[ba])
  - 001 ALU-imm: as ALU-reg, but the B operand is zero-extended imm3
  - 010 LOAD: rf[da] <= mem[rf[aa]]
  - 011 STORE: mem[rf[aa]] <= rf[ba]
  - 100 BRZ: if z_flag, pc <= pc + off6
  - 101 BRN: if n_flag, pc <= pc + off6
  - 110 JMP: pc <= rf[aa]
  - 111 HALT
- States:
  - IDLE -> FETCH unconditionally.
  - FETCH: imem_req = 1. When imem_ack = 1: ir <= imem_rdata, pc <= pc + 1, go to EXEC.
  - EXEC: cls 010/011 -> MEM; cls 111 -> HALT; all others -> FETCH.
  - MEM: dmem_req = 1. When dmem_ack = 1 -> FETCH.
  - HALT: terminal.
- Outputs derived from IR, valid in EXEC and MEM:
  - rf_aa_out = aa, rf_ba_out = ba, fu_fs_out = fs
  - fu_a_out = rf_a_in
  - fu_b_out = imm3 zero-extended if cls = 001, else rf_b_in
- ALU writeback: in EXEC for cls 000/001, rf_we_out = 1, rf_da_out = da, rf_wd_out = fu_f_in. z_flag and n_flag are loaded from fu_z_in and fu_n_in at the end of EXEC.
- Flags change only on ALU classes. Loads, stores, branches and jumps leave them untouched.
- LOAD writeback: rf_we_out = 1 in the MEM cycle where dmem_ack = 1, with rf_wd_out = dmem_rdata. dmem_we = 1 only for STORE.
- Branch target uses the already-incremented PC, so off6 = 0 falls through. Address arithmetic is modulo 2^16 and wraps silently; pc 16'hFFFF increments to 16'h0000.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- HALT: halted = 1, no requests issued; only rst_n leaves the state.

## Timing
- Reset values (asynchronous, immediate on rst_n low): state IDLE, pc = RESET_PC, ir = 0, z_flag = n_flag = 0.
- All outputs are 0 during reset; imem_addr shows RESET_PC.
- Reset mid-transfer drops imem_req/dmem_req in the same cycle. An outstanding ack after reset is ignored.
- First imem_req: the first cycle after rst_n deasserts, following one IDLE cycle.
- Requests are held high until ack is sampled and drop the next cycle. Address and wdata are stable for the whole request.
- Zero-wait memory gives these throughputs:
  - ALU, branch, JMP: 2 cycles (FETCH, EXEC)
  - LOAD/STORE: 3 cycles
  - Each memory wait cycle adds 1 cycle.
- rf_we_out is a single-cycle pulse per writing instruction, never asserted in FETCH.

## Test plan
- Reset with RESET_PC = 16'h0010, imem_ack tied high -> imem_req rises one cycle after rst_n release, imem_addr = 16'h0010, then 16'h0011 two cycles later.
- ALU-imm fs = FINC, da = 1, aa = 2, rf[2] = 16'h7FFF -> fu_a_out = 16'h7FFF, fu_b_out = 16'h0000 (imm3 = 0), rf_we_out pulse with rf_da_out = 1 and rf_wd_out = fu_f_in, in the EXEC cycle.
- STORE with rf[aa] = 16'h0100, rf[ba] = 16'hBEEF, dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we = 1, dmem_addr = 16'h0100, dmem_wdata = 16'hBEEF, no rf write.
- FSUB producing z = 1, then BRZ off6 = 6'b111110 at pc 16'h0020 -> next fetch at 16'h001F. Repeat with z = 0 -> next fetch at 16'h0021.
- LOAD, then assert rst_n low while dmem_req is high -> dmem_req = 0 immediately, pc = RESET_PC. A stale dmem_ack after release causes no rf write.
- HALT -> halted = 1, no further imem_req for 100 cycles even with imem_ack toggling.
